// File: rtl/red_tile_tracker.sv
// red_tile_tracker: classifies a 640x480 RGB444 raster stream into red / not red,
// accumulates a bounding box and hit count for each of 16 screen tiles (4x4 grid,
// 160x120 each) and publishes per-tile detection, box and aim point at end of frame.
module red_tile_tracker #(
    parameter int unsigned R_MIN     = 8,
    parameter int unsigned DIFF      = 4,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_valid,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic [11:0]       img_bg,
    output logic [15:0][9:0]  aim_x_all,
    output logic [15:0][9:0]  aim_y_all,
    output logic [15:0]       aim_detected_all,
    output logic [15:0][11:0] box_x_min_all,
    output logic [15:0][11:0] box_x_max_all,
    output logic [15:0][11:0] box_y_min_all,
    output logic [15:0][11:0] box_y_max_all,
    output logic              frame_done
);

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned BOX_W     = 12;
    localparam int unsigned CNT_W     = 15;
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned COMP_W    = 4;
    localparam int unsigned NUM_TILES = 16;
    localparam int unsigned H_ACT     = 640;
    localparam int unsigned V_ACT     = 480;
    localparam int unsigned TILE_W    = 160;
    localparam int unsigned TILE_H    = 120;

    localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Stage 1: classification and tile lookup
    // ------------------------------------------------------------------
    logic [COMP_W-1:0] r_c;
    logic [COMP_W-1:0] g_c;
    logic [COMP_W-1:0] b_c;
    logic              in_range_c;
    logic              red_c;
    logic              sof_c;
    logic              eof_c;
    logic [1:0]        tx_c;
    logic [1:0]        ty_c;

    assign r_c = img_bg[11:8];
    assign g_c = img_bg[7:4];
    assign b_c = img_bg[3:0];

    // Red test with 5-bit margin sums so G+DIFF / B+DIFF never wrap
    always_comb begin
        in_range_c = pixel_valid
                     && (x_pixel < COORD_W'(H_ACT))
                     && (y_pixel < COORD_W'(V_ACT));
        red_c = in_range_c
                && (r_c >= COMP_W'(R_MIN))
                && ({1'b0, r_c} >= ({1'b0, g_c} + 5'(DIFF)))
                && ({1'b0, r_c} >= ({1'b0, b_c} + 5'(DIFF)));
        sof_c = in_range_c && (x_pixel == '0) && (y_pixel == '0);
        eof_c = in_range_c && (x_pixel == COORD_W'(H_ACT - 1))
                           && (y_pixel == COORD_W'(V_ACT - 1));
    end

    // Tile column/row by threshold compares instead of division
    always_comb begin
        if (x_pixel < COORD_W'(TILE_W)) begin
            tx_c = 2'd0;
        end else if (x_pixel < COORD_W'(2 * TILE_W)) begin
            tx_c = 2'd1;
        end else if (x_pixel < COORD_W'(3 * TILE_W)) begin
            tx_c = 2'd2;
        end else begin
            tx_c = 2'd3;
        end
        if (y_pixel < COORD_W'(TILE_H)) begin
            ty_c = 2'd0;
        end else if (y_pixel < COORD_W'(2 * TILE_H)) begin
            ty_c = 2'd1;
        end else if (y_pixel < COORD_W'(3 * TILE_H)) begin
            ty_c = 2'd2;
        end else begin
            ty_c = 2'd3;
        end
    end

    logic               s1_red_q;
    logic               s1_sof_q;
    logic               s1_eof_q;
    logic [IDX_W-1:0]   s1_idx_q;
    logic [COORD_W-1:0] s1_x_q;
    logic [COORD_W-1:0] s1_y_q;

    // Stage 1 pipeline register; markers only fire for in-range valid pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_red_q <= 1'b0;
            s1_sof_q <= 1'b0;
            s1_eof_q <= 1'b0;
            s1_idx_q <= '0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
        end else begin
            s1_red_q <= red_c;
            s1_sof_q <= sof_c;
            s1_eof_q <= eof_c;
            s1_idx_q <= {ty_c, tx_c};
            s1_x_q   <= x_pixel;
            s1_y_q   <= y_pixel;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: per-tile accumulators and frame sequencing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   cnt_q  [NUM_TILES];
    logic [CNT_W-1:0]   cnt_d  [NUM_TILES];
    logic [COORD_W-1:0] xmin_q [NUM_TILES];
    logic [COORD_W-1:0] xmin_d [NUM_TILES];
    logic [COORD_W-1:0] xmax_q [NUM_TILES];
    logic [COORD_W-1:0] xmax_d [NUM_TILES];
    logic [COORD_W-1:0] ymin_q [NUM_TILES];
    logic [COORD_W-1:0] ymin_d [NUM_TILES];
    logic [COORD_W-1:0] ymax_q [NUM_TILES];
    logic [COORD_W-1:0] ymax_d [NUM_TILES];
    logic               in_frame_q;
    logic               in_frame_d;
    logic               commit_q;
    logic               commit_d;
    logic               reinit_c;

    // Reinit on commit or sof first, then fold in the stage-1 pixel
    always_comb begin
        reinit_c = commit_q || s1_sof_q;
        for (int k = 0; k < NUM_TILES; k++) begin
            if (reinit_c) begin
                cnt_d[k]  = '0;
                xmin_d[k] = COORD_MAX;
                xmax_d[k] = '0;
                ymin_d[k] = COORD_MAX;
                ymax_d[k] = '0;
            end else begin
                cnt_d[k]  = cnt_q[k];
                xmin_d[k] = xmin_q[k];
                xmax_d[k] = xmax_q[k];
                ymin_d[k] = ymin_q[k];
                ymax_d[k] = ymax_q[k];
            end
            if (s1_red_q && (s1_idx_q == IDX_W'(k))) begin
                if (cnt_d[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_d[k] + CNT_W'(1);
                end
                if (s1_x_q < xmin_d[k]) xmin_d[k] = s1_x_q;
                if (s1_x_q > xmax_d[k]) xmax_d[k] = s1_x_q;
                if (s1_y_q < ymin_d[k]) ymin_d[k] = s1_y_q;
                if (s1_y_q > ymax_d[k]) ymax_d[k] = s1_y_q;
            end
        end
    end

    // A commit needs a frame opened by sof; eof closes it and arms the commit
    always_comb begin
        in_frame_d = in_frame_q;
        commit_d   = s1_eof_q && in_frame_q;
        if (s1_sof_q) begin
            in_frame_d = 1'b1;
        end else if (s1_eof_q) begin
            in_frame_d = 1'b0;
        end
    end

    // Accumulator and sequencing registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TILES; k++) begin
                cnt_q[k]  <= '0;
                xmin_q[k] <= COORD_MAX;
                xmax_q[k] <= '0;
                ymin_q[k] <= COORD_MAX;
                ymax_q[k] <= '0;
            end
            in_frame_q <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TILES; k++) begin
                cnt_q[k]  <= cnt_d[k];
                xmin_q[k] <= xmin_d[k];
                xmax_q[k] <= xmax_d[k];
                ymin_q[k] <= ymin_d[k];
                ymax_q[k] <= ymax_d[k];
            end
            in_frame_q <= in_frame_d;
            commit_q   <= commit_d;
        end
    end

    // ------------------------------------------------------------------
    // Commit: per-tile result from the closed frame's accumulators
    // ------------------------------------------------------------------
    logic [COORD_W:0]            sum_x_c [NUM_TILES];
    logic [COORD_W:0]            sum_y_c [NUM_TILES];
    logic [NUM_TILES-1:0]        det_d;
    logic [15:0][COORD_W-1:0]    aim_x_d;
    logic [15:0][COORD_W-1:0]    aim_y_d;
    logic [15:0][BOX_W-1:0]      bx_min_d;
    logic [15:0][BOX_W-1:0]      bx_max_d;
    logic [15:0][BOX_W-1:0]      by_min_d;
    logic [15:0][BOX_W-1:0]      by_max_d;

    // Tiles below the hit threshold publish all-zero fields
    always_comb begin
        det_d    = '0;
        aim_x_d  = '0;
        aim_y_d  = '0;
        bx_min_d = '0;
        bx_max_d = '0;
        by_min_d = '0;
        by_max_d = '0;
        for (int k = 0; k < NUM_TILES; k++) begin
            sum_x_c[k] = {1'b0, xmin_q[k]} + {1'b0, xmax_q[k]};
            sum_y_c[k] = {1'b0, ymin_q[k]} + {1'b0, ymax_q[k]};
            if (cnt_q[k] >= CNT_W'(MIN_COUNT)) begin
                det_d[k]    = 1'b1;
                bx_min_d[k] = BOX_W'(xmin_q[k]);
                bx_max_d[k] = BOX_W'(xmax_q[k]);
                by_min_d[k] = BOX_W'(ymin_q[k]);
                by_max_d[k] = BOX_W'(ymax_q[k]);
                aim_x_d[k]  = sum_x_c[k][COORD_W:1];
                aim_y_d[k]  = sum_y_c[k][COORD_W:1];
            end
        end
    end

    logic [NUM_TILES-1:0]     det_q;
    logic [15:0][COORD_W-1:0] aim_x_q;
    logic [15:0][COORD_W-1:0] aim_y_q;
    logic [15:0][BOX_W-1:0]   bx_min_q;
    logic [15:0][BOX_W-1:0]   bx_max_q;
    logic [15:0][BOX_W-1:0]   by_min_q;
    logic [15:0][BOX_W-1:0]   by_max_q;
    logic                     frame_done_q;

    // Output registers update only on commit and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_q        <= '0;
            aim_x_q      <= '0;
            aim_y_q      <= '0;
            bx_min_q     <= '0;
            bx_max_q     <= '0;
            by_min_q     <= '0;
            by_max_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= commit_q;
            if (commit_q) begin
                det_q    <= det_d;
                aim_x_q  <= aim_x_d;
                aim_y_q  <= aim_y_d;
                bx_min_q <= bx_min_d;
                bx_max_q <= bx_max_d;
                by_min_q <= by_min_d;
                by_max_q <= by_max_d;
            end
        end
    end

    assign aim_detected_all = det_q;
    assign aim_x_all        = aim_x_q;
    assign aim_y_all        = aim_y_q;
    assign box_x_min_all    = bx_min_q;
    assign box_x_max_all    = bx_max_q;
    assign box_y_min_all    = by_min_q;
    assign box_y_max_all    = by_max_q;
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_red_tile_tracker.sv
// Bench for red_tile_tracker: directed scenarios plus random sparse frames checked
// against a per-frame model built from lists of red pixel coordinates.
module tb_red_tile_tracker;

    localparam int unsigned R_MIN     = 8;
    localparam int unsigned DIFF      = 4;
    localparam int unsigned MIN_COUNT = 64;

    logic              clk;
    logic              rst_n;
    logic              pixel_valid;
    logic [9:0]        x_pixel;
    logic [9:0]        y_pixel;
    logic [11:0]       img_bg;
    logic [15:0][9:0]  aim_x_all;
    logic [15:0][9:0]  aim_y_all;
    logic [15:0]       aim_detected_all;
    logic [15:0][11:0] box_x_min_all;
    logic [15:0][11:0] box_x_max_all;
    logic [15:0][11:0] box_y_min_all;
    logic [15:0][11:0] box_y_max_all;
    logic              frame_done;

    red_tile_tracker #(
        .R_MIN(R_MIN),
        .DIFF(DIFF),
        .MIN_COUNT(MIN_COUNT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pixel_valid(pixel_valid),
        .x_pixel(x_pixel),
        .y_pixel(y_pixel),
        .img_bg(img_bg),
        .aim_x_all(aim_x_all),
        .aim_y_all(aim_y_all),
        .aim_detected_all(aim_detected_all),
        .box_x_min_all(box_x_min_all),
        .box_x_max_all(box_x_max_all),
        .box_y_min_all(box_y_min_all),
        .box_y_max_all(box_y_max_all),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
    } pt_t;

    int    total = 0;
    int    bad   = 0;
    int    fd_seen = 0;
    int    fd_exp  = 0;
    int    cd      = 0;
    bit    in_frame = 0;
    pt_t   redq[$];
    string step = "init";

    logic [15:0]       exp_det, pend_det;
    logic [15:0][9:0]  exp_ax, exp_ay, pend_ax, pend_ay;
    logic [15:0][11:0] exp_x0, exp_x1, exp_y0, exp_y1;
    logic [15:0][11:0] pend_x0, pend_x1, pend_y0, pend_y1;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_seen++;
    end

    function automatic bit is_red(input logic [11:0] c);
        int r = int'(c[11:8]);
        int g = int'(c[7:4]);
        int b = int'(c[3:0]);
        return (r >= int'(R_MIN)) && (r >= g + int'(DIFF)) && (r >= b + int'(DIFF));
    endfunction

    // Whole-frame result from the list of red pixel coordinates
    function automatic void compute_frame();
        int cnt[16];
        int mnx[16], mxx[16], mny[16], mxy[16];
        for (int k = 0; k < 16; k++) begin
            cnt[k] = 0; mnx[k] = 1023; mxx[k] = 0; mny[k] = 1023; mxy[k] = 0;
        end
        foreach (redq[i]) begin
            int t = (redq[i].y / 120) * 4 + (redq[i].x / 160);
            cnt[t]++;
            if (redq[i].x < mnx[t]) mnx[t] = redq[i].x;
            if (redq[i].x > mxx[t]) mxx[t] = redq[i].x;
            if (redq[i].y < mny[t]) mny[t] = redq[i].y;
            if (redq[i].y > mxy[t]) mxy[t] = redq[i].y;
        end
        pend_det = '0; pend_ax = '0; pend_ay = '0;
        pend_x0 = '0; pend_x1 = '0; pend_y0 = '0; pend_y1 = '0;
        for (int k = 0; k < 16; k++) begin
            if (cnt[k] >= int'(MIN_COUNT)) begin
                pend_det[k] = 1'b1;
                pend_x0[k]  = 12'(mnx[k]);
                pend_x1[k]  = 12'(mxx[k]);
                pend_y0[k]  = 12'(mny[k]);
                pend_y1[k]  = 12'(mxy[k]);
                pend_ax[k]  = 10'((mnx[k] + mxx[k]) / 2);
                pend_ay[k]  = 10'((mny[k] + mxy[k]) / 2);
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, expv);
        end
    endtask

    task automatic check_outputs();
        chk("detected", 192'(aim_detected_all), 192'(exp_det));
        chk("aim_x", 192'(aim_x_all), 192'(exp_ax));
        chk("aim_y", 192'(aim_y_all), 192'(exp_ay));
        chk("box_x_min", 192'(box_x_min_all), 192'(exp_x0));
        chk("box_x_max", 192'(box_x_max_all), 192'(exp_x1));
        chk("box_y_min", 192'(box_y_min_all), 192'(exp_y0));
        chk("box_y_max", 192'(box_y_max_all), 192'(exp_y1));
    endtask

    task automatic clear_expect();
        exp_det = '0; exp_ax = '0; exp_ay = '0;
        exp_x0 = '0; exp_x1 = '0; exp_y0 = '0; exp_y1 = '0;
    endtask

    // One clock of input; checks the eof->frame_done timeline and updates the model
    task automatic send(input bit v, input int x, input int y, input logic [11:0] c);
        bit inr;
        pixel_valid = v;
        x_pixel     = 10'(x);
        y_pixel     = 10'(y);
        img_bg      = c;
        @(posedge clk);
        #1;
        if (cd > 0) begin
            cd--;
            if (cd == 2) begin
                chk("fd_low_e1", 192'(frame_done), 192'(0));
            end else if (cd == 1) begin
                exp_det = pend_det; exp_ax = pend_ax; exp_ay = pend_ay;
                exp_x0 = pend_x0; exp_x1 = pend_x1; exp_y0 = pend_y0; exp_y1 = pend_y1;
                fd_exp++;
                chk("fd_high_e2", 192'(frame_done), 192'(1));
                check_outputs();
            end else begin
                chk("fd_low_e3", 192'(frame_done), 192'(0));
            end
        end
        inr = v && (x < 640) && (y < 480);
        if (inr && x == 0 && y == 0) begin
            in_frame = 1;
            redq.delete();
        end
        if (inr && is_red(c)) redq.push_back('{x: x, y: y});
        if (inr && x == 639 && y == 479) begin
            if (in_frame) begin
                compute_frame();
                cd = 3;
            end
            in_frame = 0;
            redq.delete();
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 0, 0, 12'h000);
    endtask

    task automatic rnd_in_tile(input int t, output int x, output int y);
        do begin
            x = (t % 4) * 160 + int'($urandom_range(0, 159));
            y = (t / 4) * 120 + int'($urandom_range(0, 119));
        end while ((x == 0 && y == 0) || (x == 639 && y == 479));
    endtask

    task automatic gray_noise(input int n);
        int x, y;
        for (int i = 0; i < n; i++) begin
            rnd_in_tile(int'($urandom_range(0, 15)), x, y);
            send(1, x, y, 12'h888);
        end
    endtask

    task automatic model_reset();
        in_frame = 0;
        redq.delete();
        cd = 0;
        clear_expect();
    endtask

    initial begin
        int x, y, fd_mark;
        logic [11:0] col;
        rst_n = 1'b0;
        pixel_valid = 1'b0;
        x_pixel = '0;
        y_pixel = '0;
        img_bg  = '0;
        model_reset();

        // Reset state
        step = "reset";
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        chk("fd_reset", 192'(frame_done), 192'(0));
        rst_n = 1'b1;
        idle(2);

        // Single blob in tile 5 over a gray frame
        step = "blob";
        send(1, 0, 0, 12'h888);
        gray_noise(20);
        for (int yy = 130; yy <= 149; yy++)
            for (int xx = 200; xx <= 219; xx++)
                send(1, xx, yy, 12'hF00);
        gray_noise(20);
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("blob_det", 192'(aim_detected_all), 192'(16'h0020));
        chk("blob_aim", 192'({aim_x_all[5], aim_y_all[5]}), 192'({10'd209, 10'd139}));
        chk("blob_box", 192'({box_x_min_all[5], box_x_max_all[5], box_y_min_all[5], box_y_max_all[5]}),
            192'({12'd200, 12'd219, 12'd130, 12'd149}));

        // Reset in the middle of a red frame
        step = "reset_mid";
        send(1, 0, 0, 12'h888);
        for (int i = 0; i < 100; i++) begin
            rnd_in_tile(9, x, y);
            send(1, x, y, 12'hF00);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("fd_in_reset", 192'(frame_done), 192'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fd_mark = fd_seen;
        send(1, 639, 479, 12'hF00);
        idle(4);
        chk("no_commit_without_sof", 192'(fd_seen - fd_mark), 192'(0));
        send(1, 0, 0, 12'h888);
        gray_noise(30);
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("clean_det", 192'(aim_detected_all), 192'(16'h0000));

        // Hit threshold: 63 in tile 0, 64 in tile 15
        step = "threshold";
        send(1, 0, 0, 12'h888);
        for (int i = 0; i < 63; i++) send(1, 10 + i, 5, 12'hF00);
        for (int i = 0; i < 64; i++) send(1, 500 + i, 400, 12'hF00);
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("thr_det", 192'(aim_detected_all), 192'(16'h8000));

        // Tile boundary at x=159/160
        step = "boundary";
        send(1, 0, 0, 12'h888);
        for (int yy = 10; yy < 74; yy++) begin
            send(1, 159, yy, 12'hF00);
            send(1, 160, yy, 12'hF00);
        end
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("bnd_det", 192'(aim_detected_all), 192'(16'h0003));
        chk("bnd_t0_x", 192'({box_x_min_all[0], box_x_max_all[0]}), 192'({12'd159, 12'd159}));
        chk("bnd_t1_x", 192'({box_x_min_all[1], box_x_max_all[1]}), 192'({12'd160, 12'd160}));

        // Colour margin: only 12'hF00 qualifies
        step = "colour";
        send(1, 0, 0, 12'h888);
        for (int i = 0; i < 64; i++) begin
            send(1, 330 + i, 130, 12'hF00);
            send(1, 490 + i, 130, 12'hFC0);
            send(1, 10 + i, 250, 12'h700);
        end
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("col_det", 192'(aim_detected_all), 192'(16'h0040));

        // Frame abort by a second sof
        step = "abort";
        fd_mark = fd_seen;
        send(1, 0, 0, 12'h888);
        for (int i = 0; i < 100; i++) begin
            rnd_in_tile(3, x, y);
            send(1, x, y, 12'hF00);
        end
        send(1, 0, 0, 12'h888);
        gray_noise(20);
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("abort_t3", 192'(aim_detected_all[3]), 192'(0));
        chk("abort_one_fd", 192'(fd_seen - fd_mark), 192'(1));

        // Back-to-back: next sof (red) lands in the commit window
        step = "b2b";
        send(1, 0, 0, 12'h888);
        for (int i = 0; i < 70; i++) begin
            rnd_in_tile(10, x, y);
            send(1, x, y, 12'hF00);
        end
        send(1, 639, 479, 12'h888);
        send(1, 0, 0, 12'hF00);
        for (int i = 0; i < 63; i++) send(1, 1 + i, 7, 12'hF00);
        send(1, 639, 479, 12'h888);
        idle(3);
        chk("b2b_det", 192'(aim_detected_all), 192'(16'h0001));

        // Random sparse frames
        for (int f = 0; f < 8; f++) begin
            step = $sformatf("rand%0d", f);
            send(1, 0, 0, 12'($urandom));
            for (int h = 0; h < 3; h++) begin
                int t = int'($urandom_range(0, 15));
                int n = int'($urandom_range(60, 160));
                for (int i = 0; i < n; i++) begin
                    rnd_in_tile(t, x, y);
                    col = {4'($urandom_range(7, 15)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    send(($urandom % 8) != 0, x, y, col);
                    if ($urandom % 10 == 0) idle(1);
                end
            end
            for (int i = 0; i < 60; i++) begin
                do begin
                    x = int'($urandom_range(0, 1023));
                    y = int'($urandom_range(0, 1023));
                end while ((x == 0 && y == 0) || (x == 639 && y == 479));
                send($urandom % 2, x, y, 12'($urandom));
            end
            send(1, 639, 479, 12'($urandom));
            if (f == 7 || ($urandom % 2) == 1) idle(3);
        end

        step = "final";
        idle(2);
        chk("frame_count", 192'(fd_seen), 192'(fd_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
